syndrome_gen_dm: RTL

//  Upstream stage of the SECDED decode path: accepts one 16-bit Hamming(15,11)+parity

---
 rtl/syndrome_gen_dm.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/syndrome_gen_dm.sv
`default_nettype none
// ============================================================================
//  Module     : syndrome_gen_dm
//  Purpose    : Upstream stage of the SECDED decode path. Accepts one 16-bit
//               Hamming(15,11)+overall-parity codeword as two bytes from data
//               memory, computes the 4-bit syndrome and the overall parity,
//               and presents them zero-extended to W bits for the decode LUT.
//               Codeword layout: bit 0 = overall parity p0, bits 1..15 =
//               Hamming positions 1..15.
//  Ports      : Clk       in   system clock (rising edge)
//               Reset_n   in   asynchronous active-low reset
//               Start     in   begin a decode (honoured in IDLE and DONE)
//               DinValid  in   Din carries a codeword byte this cycle
//               Din       in   8-bit codeword byte
//               Ready     out  a byte is taken when DinValid && Ready
//               Busy      out  high while waiting for codeword bytes
//               Done      out  Syndrome/Parity valid, held until Ack/Start
//               Ack       in   consumer has taken the result (DONE only)
//               Syndrome  out  W-bit zero-extended syndrome
//               Parity    out  W-bit zero-extended overall parity
//  Revision   : 1.0  initial release
// ============================================================================
module syndrome_gen_dm #(
  parameter int unsigned W        = 8,
  parameter int unsigned LO_FIRST = 1
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         DinValid,
  input  logic [7:0]   Din,
  output logic         Ready,
  output logic         Busy,
  output logic         Done,
  input  logic         Ack,
  output logic [W-1:0] Syndrome,
  output logic [W-1:0] Parity
);

  // Whether the first byte received is the upper half of the codeword.
  localparam logic FIRST_IS_HI = (LO_FIRST == 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_B0 = 2'd1,
    WAIT_B1 = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] syn_acc_q, syn_acc_d;
  logic       par_acc_q, par_acc_d;
  logic [3:0] syndrome_q, syndrome_d;
  logic       parity_q, parity_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       w_byte_hi;
  logic [3:0] w_fold_syn;
  logic       w_fold_par;

  // XOR of codeword indices for every set bit of a byte. For the low byte
  // bit 0 is p0 and maps to index 0, which contributes nothing.
  function automatic logic [3:0] fold_syn(input logic [7:0] b, input logic hi);
    logic [3:0] s;
    s = 4'd0;
    for (int j = 0; j < 8; j++) begin
      if (b[j]) begin
        s = s ^ {hi, 3'(j)};
      end
    end
    return s;
  endfunction

  // Byte offset depends on which byte of the pair is currently expected.
  assign w_byte_hi  = (state_q == WAIT_B0) ? FIRST_IS_HI : ~FIRST_IS_HI;
  assign w_fold_syn = fold_syn(Din, w_byte_hi);
  assign w_fold_par = ^Din;

  always_comb begin
    state_d    = state_q;
    syn_acc_d  = syn_acc_q;
    par_acc_d  = par_acc_q;
    syndrome_d = syndrome_q;
    parity_d   = parity_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = WAIT_B0;
          syn_acc_d = 4'd0;
          par_acc_d = 1'b0;
        end
      end
      WAIT_B0: begin
        if (DinValid) begin
          syn_acc_d = syn_acc_q ^ w_fold_syn;
          par_acc_d = par_acc_q ^ w_fold_par;
          state_d   = WAIT_B1;
        end
      end
      WAIT_B1: begin
        if (DinValid) begin
          syn_acc_d  = syn_acc_q ^ w_fold_syn;
          par_acc_d  = par_acc_q ^ w_fold_par;
          syndrome_d = syn_acc_q ^ w_fold_syn;
          parity_d   = par_acc_q ^ w_fold_par;
          state_d    = DONE;
        end
      end
      DONE: begin
        // Start takes priority over Ack; the previous result stays on the
        // outputs until the next codeword completes.
        if (Start) begin
          state_d   = WAIT_B0;
          syn_acc_d = 4'd0;
          par_acc_d = 1'b0;
        end else if (Ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered, so derive them from the next state.
    ready_d = (state_d == WAIT_B0) || (state_d == WAIT_B1);
    busy_d  = (state_d == WAIT_B0) || (state_d == WAIT_B1);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      syn_acc_q  <= 4'd0;
      par_acc_q  <= 1'b0;
      syndrome_q <= 4'd0;
      parity_q   <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      syn_acc_q  <= syn_acc_d;
      par_acc_q  <= par_acc_d;
      syndrome_q <= syndrome_d;
      parity_q   <= parity_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Ready    = ready_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Syndrome = W'(syndrome_q);
  assign Parity   = W'(parity_q);

endmodule
`default_nettype wire
